dmem_arbiter: RTL

//  Shares the single-port data memory (combinational read, write on posedge clk)

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between
// master 0 (CPU data port) and master 1 (loader/debug DMA).
//
// Each grant runs a burst of len+1 word beats to consecutive word
// addresses; one IDLE arbitration cycle separates any two bursts.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   mN_req          master N burst request (level, held until mN_last)
//   mN_we/addr/len  burst direction, start byte address, beats-1 (at grant)
//   mN_wd           write data for the current beat
//   mN_ack/last/rd  beat completes / final beat / read data
//   mem_we/addr/wd  memory write enable, byte address, write data
//   mem_rd          memory combinational read data
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LEN_W-1:0]  m0_len,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic              m0_last,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LEN_W-1:0]  m1_len,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic              m1_last,
    output logic [DATA_W-1:0] m1_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int PAD_W = ADDR_W - LEN_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t             state, state_n;
    logic               last_srv, last_srv_n;
    logic [ADDR_W-1:0]  base, base_n;
    logic [LEN_W-1:0]   beat, beat_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               we_q, we_n;

    logic               grant0, grant1;
    logic               own;
    logic               is_last;
    logic [ADDR_W-1:0]  beat_addr;
    logic [DATA_W-1:0]  wd_sel;

    // On a tie the master that was not served last wins.
    assign grant0 = m0_req & (~m1_req | last_srv);
    assign grant1 = m1_req & ~grant0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last_srv <= 1'b1;
            base     <= '0;
            beat     <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state    <= state_n;
            last_srv <= last_srv_n;
            base     <= base_n;
            beat     <= beat_n;
            len_q    <= len_n;
            we_q     <= we_n;
        end
    end

    always_comb begin
        state_n    = state;
        last_srv_n = last_srv;
        base_n     = base;
        beat_n     = beat;
        len_n      = len_q;
        we_n       = we_q;
        unique case (state)
            IDLE: begin
                beat_n = '0;
                unique case (1'b1)
                    grant0: begin
                        state_n = OWN0;
                        base_n  = {m0_addr[ADDR_W-1:2], 2'b00};
                        len_n   = m0_len;
                        we_n    = m0_we;
                    end
                    grant1: begin
                        state_n = OWN1;
                        base_n  = {m1_addr[ADDR_W-1:2], 2'b00};
                        len_n   = m1_len;
                        we_n    = m1_we;
                    end
                    default: ;
                endcase
            end
            OWN0, OWN1: begin
                // Exit at beat==len_q, so the counter never wraps.
                if (beat == len_q) begin
                    state_n    = IDLE;
                    last_srv_n = (state == OWN1);
                    beat_n     = '0;
                end else begin
                    beat_n = beat + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are gated by reset so an aborted burst cannot write
    // or complete a beat on the reset edge.
    assign own       = reset && (state != IDLE);
    assign is_last   = (beat == len_q);
    assign beat_addr = base + {{PAD_W{1'b0}}, beat, 2'b00};
    assign wd_sel    = (state == OWN1) ? m1_wd : m0_wd;

    always_comb begin
        m0_ack   = 1'b0;
        m0_last  = 1'b0;
        m0_rd    = '0;
        m1_ack   = 1'b0;
        m1_last  = 1'b0;
        m1_rd    = '0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (own) begin
            mem_we   = we_q;
            mem_addr = beat_addr;
            mem_wd   = we_q ? wd_sel : '0;
            if (state == OWN1) begin
                m1_ack  = 1'b1;
                m1_last = is_last;
                m1_rd   = we_q ? '0 : mem_rd;
            end else begin
                m0_ack  = 1'b1;
                m0_last = is_last;
                m0_rd   = we_q ? '0 : mem_rd;
            end
        end
    end

endmodule
